// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared FSM states, op encoding and default parameters for reg_arb
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OP_WR, OP_RD} op_t;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/reg_arb_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick favouring the master that did not win last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt
);
  assign gnt = &req ? ~last_grant : req[1];
endmodule

// File: rtl/reg_arb.sv
// reg_arb: two-master to one-slave register bus arbiter with round-robin grant and timeout
module reg_arb
  import reg_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_wen,
  input  logic [31:0] m0_waddr,
  input  logic [31:0] m0_wdata,
  input  logic [7:0]  m0_wstrb,
  input  logic        m0_ren,
  input  logic [31:0] m0_raddr,
  output logic        m0_wrdy,
  output logic        m0_rrdy,
  output logic [31:0] m0_rdata,
  input  logic        m1_wen,
  input  logic [31:0] m1_waddr,
  input  logic [31:0] m1_wdata,
  input  logic [7:0]  m1_wstrb,
  input  logic        m1_ren,
  input  logic [31:0] m1_raddr,
  output logic        m1_wrdy,
  output logic        m1_rrdy,
  output logic [31:0] m1_rdata,
  output logic        s_wen,
  output logic [31:0] s_waddr,
  output logic [31:0] s_wdata,
  output logic [7:0]  s_wstrb,
  output logic        s_ren,
  output logic [31:0] s_raddr,
  input  logic        s_wrdy,
  input  logic        s_rrdy,
  input  logic [31:0] s_rdata,
  output logic        err,
  output logic        owner
);
  state_t      state, state_nx;
  op_t         op;
  logic        last_grant, gnt, busy, slv_rdy, tmo_hit, done, wrdy, rrdy;
  logic [1:0]  req;
  logic [15:0] cnt;
  logic [31:0] rd_data;
  assign req = {m1_wen | m1_ren, m0_wen | m0_ren};
  rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );
  assign busy    = (state == BUSY) && !reset;
  assign s_wen   = busy && (op == OP_WR);
  assign s_ren   = busy && (op == OP_RD);
  assign s_waddr = s_wen ? (owner ? m1_waddr : m0_waddr) : '0;
  assign s_wdata = s_wen ? (owner ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb = s_wen ? (owner ? m1_wstrb : m0_wstrb) : '0;
  assign s_raddr = s_ren ? (owner ? m1_raddr : m0_raddr) : '0;
  assign slv_rdy = (op == OP_WR) ? s_wrdy : s_rrdy;
  assign tmo_hit = cnt == 16'(TIMEOUT - 1);
  assign done    = busy && (slv_rdy || tmo_hit);
  assign err     = busy && !slv_rdy && tmo_hit;
  assign wrdy    = s_wen && (s_wrdy || tmo_hit);
  assign rrdy    = s_ren && (s_rrdy || tmo_hit);
  assign rd_data = s_rrdy ? s_rdata : ERR_DATA;
  assign m0_wrdy  = wrdy && !owner;
  assign m1_wrdy  = wrdy && owner;
  assign m0_rrdy  = rrdy && !owner;
  assign m1_rrdy  = rrdy && owner;
  assign m0_rdata = m0_rrdy ? rd_data : '0;
  assign m1_rdata = m1_rrdy ? rd_data : '0;
  // next state: grant on any request, hold until ready or timeout, one DONE gap cycle
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (|req ? BUSY : IDLE) :
               (state == BUSY) ? (done ? DONE : BUSY) : IDLE;
  end
  // state, grant bookkeeping and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op         <= OP_WR;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        cnt <= '0;
        if (|req) begin
          owner <= gnt;
          op    <= (gnt ? m1_wen : m0_wen) ? OP_WR : OP_RD;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + 16'd1;
        if (done) last_grant <= owner;
      end
    end
  end
endmodule

// File: tb/tb_reg_arb.sv
// tb_reg_arb: randomized scoreboard bench for reg_arb against a transaction-level model
module tb_reg_arb;
  localparam int T = 4;
  logic        clk = 0, reset = 1;
  logic        m0_wen = 0, m0_ren = 0, m1_wen = 0, m1_ren = 0;
  logic [31:0] m0_waddr = 0, m0_wdata = 0, m0_raddr = 0, m1_waddr = 0, m1_wdata = 0, m1_raddr = 0;
  logic [7:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic        m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_wen, s_ren, err, owner;
  logic [31:0] s_waddr, s_wdata, s_raddr;
  logic [7:0]  s_wstrb;
  logic        s_wrdy = 0, s_rrdy = 0;
  logic [31:0] s_rdata = 0;

  reg_arb #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .m0_wen(m0_wen), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ren(m0_ren), .m0_raddr(m0_raddr), .m0_wrdy(m0_wrdy), .m0_rrdy(m0_rrdy), .m0_rdata(m0_rdata),
    .m1_wen(m1_wen), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ren(m1_ren), .m1_raddr(m1_raddr), .m1_wrdy(m1_wrdy), .m1_rrdy(m1_rrdy), .m1_rdata(m1_rdata),
    .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ren(s_ren), .s_raddr(s_raddr), .s_wrdy(s_wrdy), .s_rrdy(s_rrdy), .s_rdata(s_rdata),
    .err(err), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit m; bit w; logic [31:0] addr; logic [31:0] data; logic [7:0] strb;
    logic [31:0] rdata; bit err; int lat; bit first;
  } exp_t;
  typedef struct { int dly; logic [31:0] rdata; } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    tests = 0, fails = 0, cyc = 0, req_cyc = 0, done_cyc = 0;
  bit    mdl_last = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // model: each round's completions are derived from round-robin + write-first rules
  task automatic run_round(input bit w0, input bit r0, input bit w1, input bit r1, input int fdly);
    logic [31:0] wa[2], wd[2], ra[2];
    logic [7:0]  ws[2];
    bit pw[2], pr[2];
    bit first;
    first = 1;
    pw[0] = w0; pr[0] = r0; pw[1] = w1; pr[1] = r1;
    for (int i = 0; i < 2; i++) begin
      wa[i] = $urandom; wd[i] = $urandom; ra[i] = $urandom; ws[i] = 8'($urandom);
    end
    while (pw[0] | pr[0] | pw[1] | pr[1]) begin
      bit h0, h1, win;
      exp_t e;
      plan_t p;
      h0 = pw[0] | pr[0];
      h1 = pw[1] | pr[1];
      win = (h0 && h1) ? !mdl_last : h1;
      p.dly = (fdly >= 0) ? fdly : int'($urandom_range(0, T + 1));
      p.rdata = $urandom;
      e.m = win;
      e.w = pw[win];
      e.addr = e.w ? wa[win] : ra[win];
      e.data = e.w ? wd[win] : 0;
      e.strb = e.w ? ws[win] : 0;
      e.err = p.dly >= T;
      e.lat = e.err ? T - 1 : p.dly;
      e.rdata = e.w ? 0 : (e.err ? 32'hDEAD_BEEF : p.rdata);
      e.first = first;
      first = 0;
      if (e.w) pw[win] = 0; else pr[win] = 0;
      mdl_last = win;
      exp_q.push_back(e);
      plan_q.push_back(p);
    end
    @(posedge clk); #1;
    m0_wen = w0; m0_ren = r0; m1_wen = w1; m1_ren = r1;
    m0_waddr = wa[0]; m0_wdata = wd[0]; m0_wstrb = ws[0]; m0_raddr = ra[0];
    m1_waddr = wa[1]; m1_wdata = wd[1]; m1_wstrb = ws[1]; m1_raddr = ra[1];
    req_cyc = cyc;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL round_timeout: got %0d pending completions expected 0", exp_q.size());
      exp_q.delete(); plan_q.delete();
      m0_wen = 0; m0_ren = 0; m1_wen = 0; m1_ren = 0;
    end
    repeat (2) @(posedge clk);
  endtask

  // slave: answers each new strobe after its planned delay, with stray pulses on the idle op
  initial begin
    bit sl_act;
    int sl_cnt;
    plan_t sl_plan;
    sl_act = 0; sl_cnt = 0; sl_plan.dly = 1000; sl_plan.rdata = 0;
    forever begin
      @(posedge clk); #2;
      s_wrdy = 0; s_rrdy = 0; s_rdata = $urandom;
      if (!(s_wen || s_ren)) sl_act = 0;
      else if (!sl_act) begin
        sl_act = 1; sl_cnt = 0;
        if (plan_q.size() > 0) sl_plan = plan_q.pop_front();
        else begin sl_plan.dly = 1000; sl_plan.rdata = 0; end
      end
      if (sl_act) begin
        if (sl_cnt == sl_plan.dly) begin
          if (s_wen) s_wrdy = 1; else s_rrdy = 1;
          s_rdata = sl_plan.rdata;
        end
        if ($urandom_range(0, 3) == 0) begin
          if (s_wen) s_rrdy = 1; else s_wrdy = 1;
        end
        sl_cnt++;
      end else if ($urandom_range(0, 3) == 0) begin
        s_wrdy = 1'($urandom); s_rrdy = 1'($urandom);
      end
    end
  end

  // monitor: checks strobes and completions against the queue head
  initial begin
    bit mon_act, rst_d;
    int mon_cnt;
    exp_t e;
    mon_act = 0; rst_d = 0; mon_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_quiet", {s_wen, s_ren, m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy, err}, 0);
        mon_act = 0; rst_d = 1;
      end else begin
        if (rst_d) begin
          chk("post_reset_quiet", {s_wen, s_ren, m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy, err}, 0);
          rst_d = 0;
        end
        if ((s_wen || s_ren) && !mon_act) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_strobe: got s_wen=%b s_ren=%b expected none", s_wen, s_ren);
          end else begin
            e = exp_q[0];
            chk("s_wen", s_wen, e.w);
            chk("s_ren", s_ren, !e.w);
            chk("addr", e.w ? s_waddr : s_raddr, e.addr);
            chk("other_addr", e.w ? s_raddr : s_waddr, 0);
            chk("wdata", s_wdata, e.data);
            chk("wstrb", s_wstrb, e.strb);
            chk("owner", owner, e.m);
            chk("start_gap", e.first ? cyc - req_cyc : cyc - done_cyc, e.first ? 1 : 3);
          end
          mon_act = 1; mon_cnt = 0;
        end
        if (m0_wrdy | m0_rrdy | m1_wrdy | m1_rrdy) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_rdy: got %b expected 0000", {m1_wrdy, m1_rrdy, m0_wrdy, m0_rrdy});
          end else begin
            e = exp_q.pop_front();
            chk("rdy_vec", {m1_wrdy, m1_rrdy, m0_wrdy, m0_rrdy}, e.m ? (e.w ? 8 : 4) : (e.w ? 2 : 1));
            chk("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
            chk("other_rdata", e.m ? m0_rdata : m1_rdata, 0);
            chk("err", err, e.err);
            chk("latency", mon_cnt, e.lat);
          end
          done_cyc = cyc; mon_act = 0;
          if (m0_wrdy) m0_wen = 0;
          if (m0_rrdy) m0_ren = 0;
          if (m1_wrdy) m1_wen = 0;
          if (m1_rrdy) m1_ren = 0;
        end else begin
          chk("quiet_rdata", m0_rdata | m1_rdata, 0);
          chk("quiet_err", err, 0);
        end
        if (mon_act) mon_cnt++;
      end
    end
  end

  initial begin
    exp_t e;
    plan_t p;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    run_round(0, 1, 0, 1, 1);
    run_round(0, 1, 0, 1, 1);
    run_round(1, 0, 0, 0, 2);
    run_round(0, 0, 1, 1, 1);
    run_round(0, 1, 0, 0, 100);
    run_round(0, 0, 1, 0, -1);
    run_round(0, 1, 0, 0, T - 1);
    run_round(1, 0, 0, 0, T - 1);
    for (int i = 0; i < 40; i++)
      run_round(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    run_round(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    e.m = 0; e.w = 0; e.addr = $urandom; e.data = 0; e.strb = 0;
    e.rdata = 0; e.err = 0; e.lat = 0; e.first = 1;
    p.dly = 1000; p.rdata = 0;
    exp_q.push_back(e); plan_q.push_back(p);
    m0_raddr = e.addr; m0_ren = 1; req_cyc = cyc;
    repeat (2) @(posedge clk);
    #1 reset = 1; m1_ren = 1;
    repeat (2) @(posedge clk);
    #1 exp_q.delete(); plan_q.delete();
    m0_ren = 0; m1_ren = 0; mdl_last = 1;
    reset = 0;
    @(posedge clk);
    run_round(0, 1, 0, 1, -1);
    run_round(1, 1, 1, 1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] global timeout");
  end
endmodule

// File: doc/reg_arb.md
REG_ARB -- requirements
Module: reg_arb

Interface
REQ-001 The parameter TIMEOUT SHALL default to 255 and set the number of BUSY cycles without slave ready before forced completion (range 1..65535).
REQ-002 The parameter ERR_DATA SHALL default to 32'hDEAD_BEEF and be returned as m*_rdata on a timed-out read.
REQ-003 The port clk SHALL be a 1-bit input and the single clock; all logic is on its rising edge.
REQ-004 The port reset SHALL be a 1-bit input: synchronous, active-high reset.
REQ-005 For each master x in {0,1}, mx_wen, mx_waddr[31:0], mx_wdata[31:0], mx_wstrb[7:0], mx_ren and mx_raddr[31:0] SHALL be inputs carrying that requester's write/read request fields.
REQ-006 For each master x, mx_wrdy (1), mx_rrdy (1) and mx_rdata[31:0] SHALL be outputs carrying completion and read data.
REQ-007 The shared slave side SHALL provide outputs s_wen, s_waddr[31:0], s_wdata[31:0], s_wstrb[7:0], s_ren and s_raddr[31:0], and inputs s_wrdy, s_rrdy and s_rdata[31:0].
REQ-008 Outputs err (1-bit, single-cycle pulse on timeout) and owner (1-bit, current grant holder) SHALL be provided.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-010 Requests SHALL follow this contract: a master raises wen or ren and holds it and its fields stable until the matching rdy; the slave pulses s_wrdy/s_rrdy for one cycle, with s_rdata valid in that cycle.
REQ-011 In IDLE, a master with wen|ren asserted SHALL be requesting; with no requester the FSM stays in IDLE.
REQ-012 Arbitration SHALL be round-robin: with both masters requesting, the master other than last_grant wins; with one requester, that master wins.
REQ-013 When the winner asserts both wen and ren, the write SHALL be served first; the read is served in a later grant.
REQ-014 In IDLE the FSM SHALL register owner, op (write/read) and clear the timeout counter, then go to BUSY on the next edge, giving 1 cycle from request to slave strobe.
REQ-015 In BUSY, the slave outputs SHALL be driven combinationally from the owner's fields for op only; the other op's enable SHALL be 0 and its address/data/strobe 0.
REQ-016 In BUSY, the slave ready for op SHALL be forwarded combinationally to the owner's matching rdy (and, for reads, s_rdata to mx_rdata), and the FSM SHALL move to DONE on that edge.
REQ-017 In BUSY without the slave ready, the counter SHALL increment; when it reaches TIMEOUT-1 without ready, the owner's rdy SHALL pulse, mx_rdata=ERR_DATA for reads, err SHALL pulse, and the FSM SHALL go to DONE.
REQ-018 A slave ready arriving in the same cycle as timeout SHALL count as normal completion, with no err and the slave data returned.
REQ-019 DONE SHALL last one cycle with all slave enables 0, then return to IDLE; last_grant updates to owner on entry to DONE.
REQ-020 Outside its completion cycle, each mx_wrdy/mx_rrdy SHALL be 0 and mx_rdata SHALL be 0.
REQ-021 Slave ready pulses in IDLE or DONE, or for the non-active op, SHALL be ignored.
REQ-022 Addresses SHALL pass through unmodified; the block performs no decode or offset arithmetic.

Reset
REQ-023 While reset=1 at a clock edge, the FSM SHALL enter IDLE, clear the counter, set last_grant=1 (so m0 wins the first contention) and set owner=0.
REQ-024 While reset is asserted, and in the cycle after, all s_* enables, mx_*rdy and err SHALL be 0.
REQ-025 A reset in BUSY SHALL abandon the transaction with no rdy issued; masters re-request after reset.

Structure
REQ-026 A shared package reg_arb_pkg SHALL hold the state enum (IDLE/BUSY/DONE), the op encoding (OP_WR/OP_RD) and the default TIMEOUT/ERR_DATA constants.
REQ-027 One sub-module, rr_arb2, SHALL hold the 2-way round-robin pick (inputs req[1:0], last_grant; output gnt); it is purely combinational, with last_grant held in reg_arb.

Verification
REQ-028 Single write scenario: m0 write addr 0x10, data 0x1234, slave ready 2 cycles after s_wen -> s_wen high 1 cycle after the request, m0_wrdy one pulse, m1 untouched, err=0.
REQ-029 Contention scenario: m0 and m1 both read from the cycle after reset, slave ready in 1 cycle -> grant order m0, m1, m0 ... alternating, with a DONE gap cycle between grants.
REQ-030 Write-then-read scenario: m1 asserts wen and ren together -> write completes first, then a separate read grant; m1_rdata equals s_rdata only in the m1_rrdy cycle.
REQ-031 Timeout scenario: TIMEOUT=4, m0 read, slave silent -> m0_rrdy and err pulse after 4 BUSY cycles, m0_rdata=0xDEADBEEF; a subsequent m1 request is then granted.
REQ-032 Boundary scenario: s_rrdy in the same cycle the counter hits TIMEOUT-1 -> normal completion, err=0; a stray s_wrdy during a read is ignored.
REQ-033 Mid-operation reset scenario: reset asserted in BUSY -> no rdy pulses, IDLE afterward, and m0 wins the next contention.
